// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for serial_subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, borrow, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, borrow, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per clock, LSB first,
// with a registered borrow chained between digits.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, wd_q, wd_d, diff_q, diff_d;
    logic             br_q, br_d, borrow_q, borrow_d, zero_q, zero_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [DIGIT-1:0] a_dig, b_dig, d_dig;
    logic [DIGIT:0]   rb;
    logic [WIDTH-1:0] wd_next;

    // Ripple of full-subtractor cells over the current digit
    always_comb begin
        a_dig   = a_q[32'(cnt_q) * DIGIT +: DIGIT];
        b_dig   = b_q[32'(cnt_q) * DIGIT +: DIGIT];
        rb      = '0;
        d_dig   = '0;
        rb[0]   = br_q;
        for (int i = 0; i < DIGIT; i++) begin
            d_dig[i]  = a_dig[i] ^ b_dig[i] ^ rb[i];
            rb[i + 1] = (~a_dig[i] & b_dig[i]) | (~(a_dig[i] ^ b_dig[i]) & rb[i]);
        end
        wd_next = wd_q;
        wd_next[32'(cnt_q) * DIGIT +: DIGIT] = d_dig;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        wd_d     = wd_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.bin;
                    cnt_d   = '0;
                    wd_d    = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                wd_d  = wd_next;
                br_d  = rb[DIGIT];
                cnt_d = cnt_q + CW'(1);
                // Result registers only move on the edge into DONE
                if (cnt_q == CW'(N - 1)) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    diff_d   = wd_next;
                    borrow_d = rb[DIGIT];
                    zero_d   = (wd_next == '0);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            br_q     <= 1'b0;
            wd_q     <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            br_q     <= br_d;
            wd_q     <= wd_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: four configurations (1/1, 8/1, 8/4, 8/8) checked
// against an integer-arithmetic reference model.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(1)) if0 ();
    serial_subtractor_if #(.WIDTH(8)) if1 ();
    serial_subtractor_if #(.WIDTH(8)) if2 ();
    serial_subtractor_if #(.WIDTH(8)) if3 ();

    serial_subtractor #(.WIDTH(1), .DIGIT(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u2 (.clk(clk), .rst(rst), .bus(if2));
    serial_subtractor #(.WIDTH(8), .DIGIT(8)) u3 (.clk(clk), .rst(rst), .bus(if3));

    function automatic void drive(input int k, input logic s, input logic [7:0] a,
                                  input logic [7:0] b, input logic bi);
        case (k)
            0:       begin if0.start = s; if0.a = a[0]; if0.b = b[0]; if0.bin = bi; end
            1:       begin if1.start = s; if1.a = a;    if1.b = b;    if1.bin = bi; end
            2:       begin if2.start = s; if2.a = a;    if2.b = b;    if2.bin = bi; end
            default: begin if3.start = s; if3.a = a;    if3.b = b;    if3.bin = bi; end
        endcase
    endfunction

    function automatic logic rd_busy(input int k);
        case (k)
            0: return if0.busy; 1: return if1.busy; 2: return if2.busy;
            default: return if3.busy;
        endcase
    endfunction

    function automatic logic rd_done(input int k);
        case (k)
            0: return if0.done; 1: return if1.done; 2: return if2.done;
            default: return if3.done;
        endcase
    endfunction

    function automatic logic [7:0] rd_diff(input int k);
        case (k)
            0: return {7'b0, if0.diff}; 1: return if1.diff; 2: return if2.diff;
            default: return if3.diff;
        endcase
    endfunction

    function automatic logic rd_borrow(input int k);
        case (k)
            0: return if0.borrow; 1: return if1.borrow; 2: return if2.borrow;
            default: return if3.borrow;
        endcase
    endfunction

    function automatic logic rd_zero(input int k);
        case (k)
            0: return if0.zero; 1: return if1.zero; 2: return if2.zero;
            default: return if3.zero;
        endcase
    endfunction

    function automatic int lat_of(input int k);
        case (k)
            0: return 1; 1: return 8; 2: return 2;
            default: return 1;
        endcase
    endfunction

    // Reference: plain signed integer subtraction reduced modulo 2^W
    function automatic void model(input int k, input logic [7:0] a, input logic [7:0] b,
                                  input logic bi, output logic [7:0] d, output logic br,
                                  output logic z);
        int w    = (k == 0) ? 1 : 8;
        int mask = (1 << w) - 1;
        int t;
        t  = (int'(a) & mask) - (int'(b) & mask) - int'(bi);
        br = (t < 0);
        d  = 8'(t & mask);
        z  = ((t & mask) == 0);
    endfunction

    // One accepted operation; returns result, latency and handshake observations
    task automatic op(input int k, input logic [7:0] a, input logic [7:0] b, input logic bi,
                      output logic [7:0] d, output logic br, output logic z, output int lat,
                      output logic busy0, output logic done1, output logic busy1,
                      output logic moved);
        logic [7:0] d0;
        bit         found;
        @(negedge clk);
        drive(k, 1'b1, a, b, bi);
        @(posedge clk); #1;
        busy0 = rd_busy(k);
        d0    = rd_diff(k);
        moved = 1'b0;
        @(negedge clk);
        drive(k, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        found = 1'b0;
        lat   = -1;
        for (int c = 1; c <= 40 && !found; c++) begin
            @(posedge clk); #1;
            if (rd_done(k)) begin
                found = 1'b1;
                lat   = c;
            end else if (rd_diff(k) !== d0) begin
                moved = 1'b1;
            end
        end
        d  = rd_diff(k);
        br = rd_borrow(k);
        z  = rd_zero(k);
        @(posedge clk); #1;
        done1 = rd_done(k);
        busy1 = rd_busy(k);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({rd_busy(k), rd_done(k), rd_diff(k), rd_borrow(k), rd_zero(k)} !== 12'h000) begin
                errors++;
                $display("FAIL reset k%0d: got busy=%b done=%b diff=%h borrow=%b zero=%b want all 0",
                         k, rd_busy(k), rd_done(k), rd_diff(k), rd_borrow(k), rd_zero(k));
            end
        end
    endtask

    task automatic test_truth_table();
        logic [7:0] d, ed;
        logic       br, z, ebr, ez, b0, d1, b1, mv;
        int         lat;
        for (int i = 0; i < 8; i++) begin
            op(0, 8'(i >> 2), 8'((i >> 1) & 1), 1'(i & 1), d, br, z, lat, b0, d1, b1, mv);
            model(0, 8'(i >> 2), 8'((i >> 1) & 1), 1'(i & 1), ed, ebr, ez);
            checks++;
            if ({d, br} !== {ed, ebr}) begin
                errors++;
                $display("FAIL truth_table abc=%0d: got diff=%h borrow=%b want diff=%h borrow=%b",
                         i, d, br, ed, ebr);
            end
            checks++;
            if ({lat, b0, d1, b1} !== {32'd1, 3'b100}) begin
                errors++;
                $display("FAIL truth_table_timing abc=%0d: got lat=%0d busy0=%b done1=%b busy1=%b want 1 1 0 0",
                         i, lat, b0, d1, b1);
            end
        end
    endtask

    task automatic test_directed();
        logic [7:0] va[5]  = '{8'h5A, 8'h00, 8'hFF, 8'h10, 8'h80};
        logic [7:0] vb[5]  = '{8'h3C, 8'h01, 8'hFF, 8'h0F, 8'h01};
        logic       vi[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] ed[5]  = '{8'h1E, 8'hFF, 8'hFF, 8'h00, 8'h7F};
        logic       ebr[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       ez[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] d;
        logic       br, z, b0, d1, b1, mv;
        int         lat;
        for (int k = 1; k < 4; k++) begin
            for (int i = 0; i < 5; i++) begin
                op(k, va[i], vb[i], vi[i], d, br, z, lat, b0, d1, b1, mv);
                checks++;
                if ({d, br, z} !== {ed[i], ebr[i], ez[i]}) begin
                    errors++;
                    $display("FAIL directed k%0d #%0d: got diff=%h borrow=%b zero=%b want diff=%h borrow=%b zero=%b",
                             k, i, d, br, z, ed[i], ebr[i], ez[i]);
                end
                checks++;
                if ({lat, b0, d1, b1, mv} !== {lat_of(k), 4'b1000}) begin
                    errors++;
                    $display("FAIL directed_timing k%0d #%0d: got lat=%0d busy0=%b done1=%b busy1=%b moved=%b want %0d 1 0 0 0",
                             k, i, lat, b0, d1, b1, mv, lat_of(k));
                end
            end
        end
    endtask

    task automatic rand_thread(input int k, input int n);
        logic [7:0] a, b, d, ed;
        logic       bi, br, z, ebr, ez, b0, d1, b1, mv;
        int         lat;
        for (int i = 0; i < n; i++) begin
            a  = 8'($urandom);
            b  = (i % 16 == 0) ? a : 8'($urandom);
            bi = (i % 16 == 0) ? 1'b0 : 1'($urandom);
            op(k, a, b, bi, d, br, z, lat, b0, d1, b1, mv);
            model(k, a, b, bi, ed, ebr, ez);
            checks++;
            if ({d, br, z} !== {ed, ebr, ez}) begin
                errors++;
                $display("FAIL random k%0d a=%h b=%h bin=%b: got diff=%h borrow=%b zero=%b want diff=%h borrow=%b zero=%b",
                         k, a, b, bi, d, br, z, ed, ebr, ez);
            end
            checks++;
            if ({lat, b0, d1, b1, mv} !== {lat_of(k), 4'b1000}) begin
                errors++;
                $display("FAIL random_timing k%0d: got lat=%0d busy0=%b done1=%b busy1=%b moved=%b want %0d 1 0 0 0",
                         k, lat, b0, d1, b1, mv, lat_of(k));
            end
        end
    endtask

    task automatic test_random();
        fork
            rand_thread(1, 1000);
            rand_thread(2, 1000);
            rand_thread(3, 1000);
        join
    endtask

    task automatic test_ignore_start();
        logic [7:0] ed;
        logic       ebr, ez;
        int         e;
        @(negedge clk); drive(1, 1'b1, 8'h93, 8'h27, 1'b1);
        @(posedge clk);
        @(negedge clk); drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk); @(posedge clk);
        @(negedge clk); drive(1, 1'b1, 8'h01, 8'hFE, 1'b0);
        @(posedge clk);
        @(negedge clk); drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        e = 3;
        while (e < 40) begin
            @(posedge clk); #1;
            e++;
            if (rd_done(1)) break;
        end
        model(1, 8'h93, 8'h27, 1'b1, ed, ebr, ez);
        checks++;
        if ({e, rd_diff(1), rd_borrow(1), rd_zero(1)} !== {32'd8, ed, ebr, ez}) begin
            errors++;
            $display("FAIL ignore_start: got edge=%0d diff=%h borrow=%b zero=%b want edge=8 diff=%h borrow=%b zero=%b",
                     e, rd_diff(1), rd_borrow(1), rd_zero(1), ed, ebr, ez);
        end
        // start held across DONE: not taken at EN+1, taken at EN+2
        @(negedge clk); drive(1, 1'b1, 8'h01, 8'hFE, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (rd_busy(1) !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: got busy=%b want 0", rd_busy(1));
        end
        @(posedge clk); #1;
        checks++;
        if (rd_busy(1) !== 1'b1) begin
            errors++;
            $display("FAIL accept_at_en2: got busy=%b want 1", rd_busy(1));
        end
        @(negedge clk); drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        e = 0;
        while (e < 40) begin
            @(posedge clk); #1;
            e++;
            if (rd_done(1)) break;
        end
        model(1, 8'h01, 8'hFE, 1'b0, ed, ebr, ez);
        checks++;
        if ({e, rd_diff(1), rd_borrow(1)} !== {32'd8, ed, ebr}) begin
            errors++;
            $display("FAIL second_op: got lat=%0d diff=%h borrow=%b want lat=8 diff=%h borrow=%b",
                     e, rd_diff(1), rd_borrow(1), ed, ebr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun();
        logic [7:0] ed;
        logic       ebr, ez;
        int         e, seen;
        @(negedge clk); drive(1, 1'b1, 8'h44, 8'h11, 1'b0);
        @(posedge clk);
        @(negedge clk); drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rd_busy(1), rd_done(1), rd_diff(1), rd_borrow(1), rd_zero(1)} !== 12'h000) begin
            errors++;
            $display("FAIL reset_midrun: got busy=%b done=%b diff=%h borrow=%b zero=%b want all 0",
                     rd_busy(1), rd_done(1), rd_diff(1), rd_borrow(1), rd_zero(1));
        end
        @(negedge clk); drive(1, 1'b1, 8'h20, 8'h05, 1'b1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (rd_done(1) || rd_busy(1)) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_hold: got %0d cycles with busy/done want 0", seen);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rd_busy(1) !== 1'b1) begin
            errors++;
            $display("FAIL release_accept: got busy=%b want 1", rd_busy(1));
        end
        @(negedge clk); drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        e = 0;
        while (e < 40) begin
            @(posedge clk); #1;
            e++;
            if (rd_done(1)) break;
        end
        model(1, 8'h20, 8'h05, 1'b1, ed, ebr, ez);
        checks++;
        if ({e, rd_diff(1), rd_borrow(1), rd_zero(1)} !== {32'd8, ed, ebr, ez}) begin
            errors++;
            $display("FAIL after_reset_op: got lat=%0d diff=%h borrow=%b zero=%b want lat=8 diff=%h borrow=%b zero=%b",
                     e, rd_diff(1), rd_borrow(1), rd_zero(1), ed, ebr, ez);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 4; k++) drive(k, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst = 1'b0;
        test_truth_table();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
